// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry elastic pipeline stage register; optional perf counters via PIPE_STAGE_PERF_EN
module pipe_stage_reg #(
    parameter int unsigned       DATA_W = 128,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int unsigned       CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              push;
    logic              pop;

    // in_ready and out_valid are flops, so there is no combinational path from input to output
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = main_q;

    // Occupancy state machine: main register feeds the next stage, skid absorbs one stalled entry
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            main_q    <= BUBBLE;
            skid_q    <= BUBBLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        main_q    <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        skid_q   <= in_data;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        main_q    <= BUBBLE;
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q   <= skid_q;
                        skid_q   <= BUBBLE;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_q    <= BUBBLE;
                    skid_q    <= BUBBLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating stall/bubble counters; judged on pre-edge state, so a flushed cycle still counts
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table, corner sequences and random scoreboard check of pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 16;
    localparam logic [DW-1:0] BUB = 16'hDEAD;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .BUBBLE (BUB),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    typedef struct {
        logic          rst;
        logic          fl;
        logic          iv;
        logic          ordy;
        logic [DW-1:0] d;
        logic          e_valid;
        logic          e_ready;
        logic [DW-1:0] e_data;
        string         name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic [DW-1:0] d, input logic ev, input logic er,
                       input logic [DW-1:0] ed, input string name);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
        v.e_valid = ev; v.e_ready = er; v.e_data = ed; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [DW-1:0] d);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy; in_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model state: queue of held entries plus saturating counters
    logic [DW-1:0] mq[$];
    int            m_stall;
    int            m_bubble;

    task automatic model_edge(input logic rst, input logic fl, input logic iv, input logic ordy,
                              input logic [DW-1:0] d);
        bit acc;
        bit deliver;
        int cmax;
        cmax = (1 << CW) - 1;
        acc = iv && (mq.size() < 2);
        deliver = (mq.size() > 0) && ordy;
        if (rst) begin
            m_stall = 0;
            m_bubble = 0;
        end else begin
            if (mq.size() > 0 && !ordy && m_stall < cmax) m_stall++;
            if (mq.size() == 0 && m_bubble < cmax) m_bubble++;
        end
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (deliver) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    initial begin
        // test 1: reset held two cycles
        add(1, 0, 0, 0, 16'h0000, 0, 1, BUB, "reset0");
        add(1, 0, 0, 0, 16'h0000, 0, 1, BUB, "reset1");
        // test 2: stream 1..8 at full rate
        for (int i = 1; i <= 8; i++)
            add(0, 0, 1, 1, DW'(i), 1, 1, DW'(i), "stream");
        add(0, 0, 0, 1, 16'h0000, 0, 1, BUB, "stream_drain");
        // idle with garbage data and in_valid low must not be sampled
        add(0, 0, 0, 1, 16'hFFFF, 0, 1, BUB, "idle_nosample");
        // test 3: fill to TWO, then drain in order
        add(0, 0, 1, 0, 16'h000A, 1, 1, 16'h000A, "fill_a");
        add(0, 0, 1, 0, 16'h000B, 1, 0, 16'h000A, "fill_b");
        add(0, 0, 1, 0, 16'h000C, 1, 0, 16'h000A, "two_hold");
        add(0, 0, 0, 1, 16'h0000, 1, 1, 16'h000B, "drain_a");
        add(0, 0, 0, 0, 16'h5555, 1, 1, 16'h000B, "one_hold");
        add(0, 0, 0, 1, 16'h0000, 0, 1, BUB, "drain_b");
        // test 4: flush in TWO with a same-cycle offer
        add(0, 0, 1, 0, 16'h000A, 1, 1, 16'h000A, "f_fill_a");
        add(0, 0, 1, 0, 16'h000B, 1, 0, 16'h000A, "f_fill_b");
        add(0, 1, 1, 1, 16'h000C, 0, 1, BUB, "flush_two");
        add(0, 0, 0, 1, 16'h0000, 0, 1, BUB, "after_flush");
        // flush in ONE with push and pop both pending
        add(0, 0, 1, 0, 16'h0011, 1, 1, 16'h0011, "f1_fill");
        add(0, 1, 1, 1, 16'h0022, 0, 1, BUB, "flush_one");
        // reset in TWO
        add(0, 0, 1, 0, 16'h0033, 1, 1, 16'h0033, "r_fill_a");
        add(0, 0, 1, 0, 16'h0044, 1, 0, 16'h0033, "r_fill_b");
        add(1, 1, 1, 1, 16'h0055, 0, 1, BUB, "reset_two");
        add(0, 0, 1, 1, 16'h0066, 1, 1, 16'h0066, "post_reset");
        add(0, 0, 0, 1, 16'h0000, 0, 1, BUB, "post_drain");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].d);
            step();
            chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'(vecs[i].e_valid));
            chk({vecs[i].name, "_ready"}, 32'(in_ready), 32'(vecs[i].e_ready));
            chk({vecs[i].name, "_data"}, 32'(out_data), 32'(vecs[i].e_data));
        end

`ifdef PIPE_STAGE_PERF_EN
        // test 5: stall counter saturation, flush keeps, reset clears
        drive(1, 0, 0, 0, '0); step();
        chk("cnt_reset_stall", 32'(stall_cnt), 32'd0);
        chk("cnt_reset_bubble", 32'(bubble_cnt), 32'd0);
        drive(0, 0, 1, 0, 16'h0077); step();
        drive(0, 0, 0, 0, '0);
        for (int i = 0; i < 20; i++) step();
        chk("cnt_stall_sat", 32'(stall_cnt), 32'hF);
        chk("cnt_bubble_one", 32'(bubble_cnt), 32'd1);
        drive(0, 1, 0, 0, '0); step();
        chk("cnt_flush_keep", 32'(stall_cnt), 32'hF);
        chk("cnt_flush_bubble", 32'(bubble_cnt), 32'd1);
        drive(0, 0, 0, 0, '0); step();
        chk("cnt_bubble_after_flush", 32'(bubble_cnt), 32'd2);
        drive(1, 0, 0, 0, '0); step();
        chk("cnt_reset_again", 32'(stall_cnt), 32'd0);
`endif

        // test 6: random traffic against the queue model
        drive(1, 0, 0, 0, '0);
        model_edge(1, 0, 0, 0, '0);
        step();
        for (int c = 0; c < 10000; c++) begin
            logic          r_rst, r_fl, r_iv, r_or;
            logic [DW-1:0] r_d;
            r_rst = ($urandom_range(0, 199) == 0);
            r_fl  = ($urandom_range(0, 63) == 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_or  = ($urandom_range(0, 2) != 0);
            r_d   = DW'($urandom);
            drive(r_rst, r_fl, r_iv, r_or, r_d);
            model_edge(r_rst, r_fl, r_iv, r_or, r_d);
            step();
            chk("rnd_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("rnd_ready", 32'(in_ready), 32'(mq.size() < 2));
            chk("rnd_data", 32'(out_data), 32'((mq.size() > 0) ? mq[0] : BUB));
`ifdef PIPE_STAGE_PERF_EN
            chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("rnd_bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
